req_encoder_6to3: RTL and testbench

REQ_ENCODER_6TO3 -- requirements
Module: req_encoder_6to3

---
 rtl/req_enc_pkg.sv | 10 +
 rtl/req_enc_pick.sv | 26 ++
 rtl/req_encoder_6to3.sv | 105 ++++++++++
 tb/tb_req_encoder_6to3.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared sizes and output-stage state type for the 6-to-3 request encoder.
package req_enc_pkg;
    localparam int N_REQ  = 6;
    localparam int CODE_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } enc_state_t;
endpackage

// File: rtl/req_enc_pick.sv
// Circular first-set search over the pending vector, starting at a given index.
module req_enc_pick #(
    parameter int N_REQ  = req_enc_pkg::N_REQ,
    parameter int CODE_W = req_enc_pkg::CODE_W
) (
    input  logic [N_REQ-1:0]  pend,
    input  logic [CODE_W-1:0] start,
    output logic              found,
    output logic [CODE_W-1:0] idx
);
    import req_enc_pkg::*;

    always_comb begin
        logic [CODE_W-1:0] j;
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = CODE_W'((32'(start) + k) % N_REQ);
            if (!found && pend[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/req_encoder_6to3.sv
// Request lines to queued 3-bit codes with valid/ready output stage.
// Define REQ_ENC_RR_EN for round-robin grant; default is fixed lowest-index priority.
module req_encoder_6to3 #(
    parameter int N_REQ  = req_enc_pkg::N_REQ,
    parameter int CODE_W = req_enc_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [N_REQ-1:0]  pend,
    output logic              overflow
);
    import req_enc_pkg::*;

    enc_state_t        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [N_REQ-1:0]  pend_d;
    logic              ovf_d;
    logic [N_REQ-1:0]  grant_oh;
    logic [CODE_W-1:0] start;
    logic              found;
    logic [CODE_W-1:0] pick_idx;
    logic              load;

`ifdef REQ_ENC_RR_EN
    logic [CODE_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= CODE_W'(N_REQ - 1);
        end else if (load) begin
            last_q <= pick_idx;
        end
    end

    assign start = (last_q == CODE_W'(N_REQ - 1)) ? '0 : last_q + 1'b1;
`else
    assign start = '0;
`endif

    req_enc_pick #(
        .N_REQ (N_REQ),
        .CODE_W(CODE_W)
    ) u_pick (
        .pend (pend),
        .start(start),
        .found(found),
        .idx  (pick_idx)
    );

    // In FULL out_valid is 1, so a handshake reduces to out_ready.
    assign load = found && ((state_q == EMPTY) || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            code_q   <= '0;
            pend     <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pend     <= pend_d;
            overflow <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        pend_d   = pend;
        ovf_d    = 1'b0;
        grant_oh = '0;
        if (load) begin
            grant_oh[pick_idx] = 1'b1;
        end

        // A new request on the bit being granted re-arms it instead of overflowing.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (en && req[i]) begin
                if (pend[i] && !grant_oh[i]) begin
                    ovf_d = 1'b1;
                end
                pend_d[i] = 1'b1;
            end else if (grant_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end

        if (load) begin
            state_d = FULL;
            code_d  = pick_idx;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
            code_d  = '0;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_code  = out_valid ? code_q : '0;
endmodule

// File: tb/tb_req_encoder_6to3.sv
// Self-checking bench for req_encoder_6to3: directed scenarios plus randomized traffic vs a reference model.
module tb_req_encoder_6to3;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [5:0] pend;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [5:0] m_pend;
    logic       m_valid;
    logic [2:0] m_code;
    logic       m_ovf;
    int         m_last;

    req_encoder_6to3 #(.N_REQ(6), .CODE_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .pend     (pend),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a set of pending indices and a one-entry output slot.
    always @(posedge clk) begin : ref_model
        int         g;
        int         s;
        logic       ld;
        logic [5:0] np;
        logic       ov;
        if (rst) begin
            m_pend  <= 6'd0;
            m_valid <= 1'b0;
            m_code  <= 3'd0;
            m_ovf   <= 1'b0;
            m_last  <= 5;
        end else begin
            ld = (m_pend != 6'd0) && (!m_valid || out_ready);
            g  = -1;
            if (ld) begin
`ifdef REQ_ENC_RR_EN
                s = (m_last + 1) % 6;
`else
                s = 0;
`endif
                for (int k = 0; k < 6; k++) begin
                    if (g < 0 && ((m_pend >> ((s + k) % 6)) & 6'd1) != 6'd0) g = (s + k) % 6;
                end
            end
            np = m_pend;
            ov = 1'b0;
            for (int i = 0; i < 6; i++) begin
                if (en && ((req >> i) & 6'd1) != 6'd0) begin
                    if (((m_pend >> i) & 6'd1) != 6'd0 && g != i) ov = 1'b1;
                    np = np | (6'd1 << i);
                end else if (g == i) begin
                    np = np & ~(6'd1 << i);
                end
            end
            m_pend <= np;
            m_ovf  <= ov;
            if (ld) begin
                m_valid <= 1'b1;
                m_code  <= 3'(g);
                m_last  <= g;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; req = 6'd0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; req = 6'b010101; out_ready = 1'b0;
        tick();
        tick();
        do_reset();
        total++;
        if (out_valid !== 1'b0 || out_code !== 3'd0) begin
            bad++; $display("FAIL reset_out: valid=%b code=%0d want valid=0 code=0", out_valid, out_code);
        end
        total++;
        if (pend !== 6'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset_pend: pend=%b ovf=%b want pend=000000 ovf=0", pend, overflow);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        req = 6'b000100;
        tick();
        req = 6'd0;
        total++;
        if (out_valid !== 1'b0 || pend !== 6'b000100) begin
            bad++; $display("FAIL single_c1: valid=%b pend=%b want valid=0 pend=000100", out_valid, pend);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 3'd2) begin
            bad++; $display("FAIL single_c2: valid=%b code=%0d want valid=1 code=2", out_valid, out_code);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || out_code !== 3'd0) begin
            bad++; $display("FAIL single_c3: valid=%b code=%0d want valid=0 code=0", out_valid, out_code);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        req = 6'b100001;
        tick();
        req = 6'd0;
        total++;
        if (pend !== 6'b100001) begin
            bad++; $display("FAIL bp_pend: pend=%b want 100001", pend);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_code !== 3'd0) begin
                bad++; $display("FAIL bp_hold%0d: valid=%b code=%0d want valid=1 code=0", c, out_valid, out_code);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 3'd5) begin
            bad++; $display("FAIL bp_second: valid=%b code=%0d want valid=1 code=5", out_valid, out_code);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || pend !== 6'd0) begin
            bad++; $display("FAIL bp_drain: valid=%b pend=%b want valid=0 pend=000000", out_valid, pend);
        end
    endtask

    task automatic test_overflow();
        int n_ovf = 0;
        int n3    = 0;
        do_reset();
        out_ready = 1'b0;
        req = 6'b000001;
        tick();
        req = 6'd0;
        tick();
        req = 6'b001000;
        tick();
        req = 6'd0;
        if (overflow === 1'b1) n_ovf++;
        total++;
        if (pend !== 6'b001000 || overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_first: pend=%b ovf=%b want pend=001000 ovf=0", pend, overflow);
        end
        tick();
        if (overflow === 1'b1) n_ovf++;
        req = 6'b001000;
        tick();
        req = 6'd0;
        if (overflow === 1'b1) n_ovf++;
        total++;
        if (overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_pulse: ovf=%b want 1", overflow);
        end
        tick();
        if (overflow === 1'b1) n_ovf++;
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (overflow === 1'b1) n_ovf++;
            if (out_valid === 1'b1 && out_code === 3'd3) n3++;
        end
        total++;
        if (n_ovf != 1) begin
            bad++; $display("FAIL ovf_count: pulses=%0d want 1", n_ovf);
        end
        total++;
        if (n3 != 1) begin
            bad++; $display("FAIL ovf_code3_count: emitted=%0d want 1", n3);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        out_ready = 1'b1;
        req = 6'b000010;
        tick();
        tick();
        req = 6'd0;
        total++;
        if (out_valid !== 1'b1 || out_code !== 3'd1 || pend !== 6'b000010 || overflow !== 1'b0) begin
            bad++; $display("FAIL setwin_load: valid=%b code=%0d pend=%b ovf=%b want 1 1 000010 0",
                            out_valid, out_code, pend, overflow);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_code !== 3'd1 || pend !== 6'd0 || overflow !== 1'b0) begin
            bad++; $display("FAIL setwin_second: valid=%b code=%0d pend=%b ovf=%b want 1 1 000000 0",
                            out_valid, out_code, pend, overflow);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL setwin_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp;
        do_reset();
        out_ready = 1'b1;
        req = 6'b111111;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
`ifdef REQ_ENC_RR_EN
            exp = 3'(k % 6);
`else
            exp = 3'd0;
`endif
            total++;
            if (out_valid !== 1'b1 || out_code !== exp) begin
                bad++; $display("FAIL fair_seq%0d: valid=%b code=%0d want valid=1 code=%0d", k, out_valid, out_code, exp);
            end
        end
        req = 6'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        req = 6'b011001;
        tick();
        req = 6'd0;
        tick();
        total++;
        if (out_valid !== 1'b1 || pend !== 6'b011000) begin
            bad++; $display("FAIL rstmid_pre: valid=%b pend=%b want valid=1 pend=011000", out_valid, pend);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || pend !== 6'd0 || out_code !== 3'd0) begin
            bad++; $display("FAIL rstmid_post: valid=%b pend=%b code=%0d want 0 000000 0", out_valid, pend, out_code);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rstmid_idle%0d: valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            en        = ($urandom_range(0, 3) != 0);
            req       = 6'($urandom) & 6'($urandom) & 6'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            total++;
            if (out_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid@%0d: got=%b want=%b", c, out_valid, m_valid);
            end
            total++;
            if (out_code !== (m_valid ? m_code : 3'd0)) begin
                bad++; $display("FAIL rnd_code@%0d: got=%0d want=%0d", c, out_code, m_valid ? m_code : 3'd0);
            end
            total++;
            if (pend !== m_pend) begin
                bad++; $display("FAIL rnd_pend@%0d: got=%b want=%b", c, pend, m_pend);
            end
            total++;
            if (overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_ovf@%0d: got=%b want=%b", c, overflow, m_ovf);
            end
            total++;
            if (out_code > 3'd5) begin
                bad++; $display("FAIL rnd_range@%0d: got=%0d want <=5", c, out_code);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 6'd0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_set_wins();
        test_fairness();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
